// File: rtl/axi_config_pkg.sv
// Shared encodings for the AXI config write path.
// Burst/response codes and the front-end state enum.
package axi_config_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for an AXI burst (FIXED/INCR/WRAP).
// Purely combinational; shared by writer and future reader.
module axi_burst_addr_gen
    import axi_config_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Wrap window is (len+1)<<size; len+1 is a power of two for legal WRAP.
    assign step      = ADDR_WIDTH'(1) << size;
    assign incr_addr = addr + step;
    assign wrap_mask = (ADDR_WIDTH'(len) << size) | (step - ADDR_WIDTH'(1));

    always_comb begin
        next_addr = addr;
        unique case (1'b1)
            burst == BURST_INCR: next_addr = incr_addr;
            burst == BURST_WRAP: next_addr = (addr & ~wrap_mask) |
                                             (incr_addr & wrap_mask);
            default:             next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_config_wr_burst.sv
// AXI4 write-slave front end for the config register bank.
// Splits bursts into single-beat register writes with backpressure.
module axi_config_wr_burst
    import axi_config_pkg::*;
#(
    parameter int                  ADDR_WIDTH   = 32,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH     = 8,
    parameter int                  BUSER_ENABLE = 0,
    parameter int                  BUSER_WIDTH  = 1,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
    parameter logic [ADDR_WIDTH:0]   ADDR_SPAN  = (ADDR_WIDTH+1)'(4096)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ID_WIDTH-1:0]    s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic [7:0]             s_axi_awlen,
    input  logic [2:0]             s_axi_awsize,
    input  logic [1:0]             s_axi_awburst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [ID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]             s_axi_bresp,
    output logic [BUSER_WIDTH-1:0] s_axi_buser,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic                   wr,
    output logic [ADDR_WIDTH-1:0]  waddr,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic [STRB_WIDTH-1:0]  wstrb,
    input  logic                   wr_ready
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

    state_e                state_q, state_d;
    logic                  awready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [8:0]            cnt_q;
    logic                  err_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    logic                  aw_hs, w_hs, wready_c, bvalid_c;
    logic                  aw_err, beat_ok, in_range, cnt_over, early_last;
    logic [ADDR_WIDTH-1:0] next_addr, size_mask, aligned;
    logic [ADDR_WIDTH:0]   offset;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign aw_err = (s_axi_awburst == BURST_RSVD) ||
                    (s_axi_awsize > SIZE_MAX) ||
                    ((s_axi_awburst == BURST_WRAP) &&
                     !wrap_len_ok(s_axi_awlen));

    // Window check via borrow so a zero base needs no constant compare.
    assign size_mask  = (ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1);
    assign aligned    = addr_q & ~size_mask;
    assign offset     = {1'b0, aligned} - {1'b0, ADDR_BASE};
    assign in_range   = !offset[ADDR_WIDTH] && (offset < ADDR_SPAN);
    assign cnt_over   = cnt_q > {1'b0, len_q};
    assign early_last = s_axi_wlast && (cnt_q != {1'b0, len_q});
    assign beat_ok    = !err_q && in_range && !cnt_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        aw_hs    = 1'b0;
        w_hs     = 1'b0;
        wready_c = 1'b0;
        bvalid_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                aw_hs = s_axi_awvalid && awready_q;
                if (aw_hs) state_d = ST_DATA;
            end
            ST_DATA: begin
                wready_c = !wr_q || wr_ready;
                w_hs     = s_axi_wvalid && wready_c;
                if (w_hs && s_axi_wlast) state_d = ST_RESP;
            end
            ST_RESP: begin
                bvalid_c = !wr_q;
                if (bvalid_c && s_axi_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awready_q <= (state_d == ST_IDLE);
            if (aw_hs) begin
                id_q    <= s_axi_awid;
                addr_q  <= s_axi_awaddr;
                len_q   <= s_axi_awlen;
                size_q  <= s_axi_awsize;
                burst_q <= s_axi_awburst;
                cnt_q   <= '0;
                err_q   <= aw_err;
            end
            if (w_hs) begin
                addr_q <= next_addr;
                if (cnt_q != 9'h1FF) cnt_q <= cnt_q + 9'd1;
                if (!beat_ok || early_last) err_q <= 1'b1;
            end
            if (w_hs && beat_ok) begin
                wr_q    <= 1'b1;
                waddr_q <= aligned;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end else if (wr_ready) begin
                wr_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_c;
    assign s_axi_bvalid  = bvalid_c;
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign wr            = wr_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign wstrb         = wstrb_q;

    if (BUSER_ENABLE != 0) begin : g_buser
        assign s_axi_buser = '0;
    end else begin : g_no_buser
        assign s_axi_buser = '0;
    end

endmodule

// File: tb/tb_axi_config_wr_burst.sv
// Directed bench for axi_config_wr_burst.
// Register writes are logged at negedge and compared per scenario.
module tb_axi_config_wr_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic [0:0]  s_axi_buser;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_strb[$];
    int          log_cyc[$];

    axi_config_wr_burst dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_buser   (s_axi_buser),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .wr            (wr),
        .waddr         (waddr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wr_ready      (wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && wr && wr_ready) begin
            log_addr.push_back(waddr);
            log_data.push_back(wdata);
            log_strb.push_back(wstrb);
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_strb.delete();
        log_cyc.delete();
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        int n;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awsize  = size;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_axi_awready) begin
            errors++;
            $display("FAIL aw_handshake: awready=%b after %0d cycles, required 1",
                     s_axi_awready, n);
        end
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
        int n;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wlast  = last;
        s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_axi_wready) begin
            errors++;
            $display("FAIL w_handshake: wready=%b after %0d cycles, required 1",
                     s_axi_wready, n);
        end
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic do_b(output logic [7:0] id, output logic [1:0] resp);
        int n;
        s_axi_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_axi_bvalid) begin
            errors++;
            $display("FAIL b_handshake: bvalid=%b after %0d cycles, required 1",
                     s_axi_bvalid, n);
            id   = 8'hxx;
            resp = 2'bxx;
        end else begin
            id   = s_axi_bid;
            resp = s_axi_bresp;
        end
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        wr_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, wr} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: aw/w/b/wr=%b, required 0000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, wr});
        end
        checks++;
        if ({waddr, wdata, wstrb, s_axi_bid, s_axi_bresp, s_axi_buser} !== '0) begin
            errors++;
            $display("FAIL reset_data: waddr=%h wdata=%h wstrb=%h bid=%h bresp=%b, required 0",
                     waddr, wdata, wstrb, s_axi_bid, s_axi_bresp);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL awready_pre_edge: got %b, required 0", s_axi_awready);
        end
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL awready_after_reset: got %b, required 1", s_axi_awready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_w_blocked();
        clear_log();
        s_axi_wdata  = 32'hDEAD_BEEF;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_axi_wready !== 1'b0) begin
            errors++;
            $display("FAIL idle_wready: got %b, required 0", s_axi_wready);
        end
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL idle_no_write: writes=%0d, required 0", log_addr.size());
        end
    endtask

    task automatic test_incr();
        logic [31:0] exp_a [4];
        logic [7:0]  id;
        logic [1:0]  resp;
        exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C};
        clear_log();
        wr_ready = 1'b1;
        do_aw(8'h5A, 32'h10, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            do_w(32'hA000_0000 + 32'(i), 4'hF, i == 3);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 4) begin
            errors++;
            $display("FAIL incr_count: writes=%0d, required 4", log_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ga, gd;
            ga = (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
            gd = (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx;
            checks++;
            if (ga !== exp_a[i] || gd !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL incr_beat%0d: waddr=%h wdata=%h, required %h %h",
                         i, ga, gd, exp_a[i], 32'hA000_0000 + 32'(i));
            end
        end
        checks++;
        if (log_cyc.size() != 4 || log_cyc[3] - log_cyc[0] != 3) begin
            errors++;
            $display("FAIL incr_consecutive: writes=%0d not one per clock",
                     log_cyc.size());
        end
        checks++;
        if (resp !== 2'b00 || id !== 8'h5A) begin
            errors++;
            $display("FAIL incr_bresp: bresp=%b bid=%h, required 00 5a", resp, id);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        logic [7:0]  id;
        logic [1:0]  resp;
        exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34};
        clear_log();
        do_aw(8'h21, 32'h38, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++)
            do_w(32'hB000_0000 + 32'(i), 4'h3, i == 3);
        do_b(id, resp);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ga;
            ga = (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
            checks++;
            if (ga !== exp_a[i]) begin
                errors++;
                $display("FAIL wrap_beat%0d: waddr=%h, required %h", i, ga, exp_a[i]);
            end
        end
        checks++;
        if (log_strb.size() != 4 || log_strb[0] !== 4'h3) begin
            errors++;
            $display("FAIL wrap_strb: writes=%0d, required 4 with strb 3",
                     log_strb.size());
        end
        checks++;
        if (resp !== 2'b00 || id !== 8'h21) begin
            errors++;
            $display("FAIL wrap_bresp: bresp=%b bid=%h, required 00 21", resp, id);
        end
    endtask

    task automatic test_fixed_stall();
        logic [31:0] exp_d [3];
        logic [7:0]  id;
        logic [1:0]  resp;
        logic        ok;
        exp_d = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        clear_log();
        wr_ready = 1'b1;
        do_aw(8'h03, 32'h40, 8'd2, 3'd2, 2'b00);
        do_w(exp_d[0], 4'hF, 1'b0);
        wr_ready     = 1'b0;
        s_axi_wdata  = exp_d[1];
        s_axi_wvalid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (s_axi_wready !== 1'b0 || wr !== 1'b1 ||
                wdata !== exp_d[0] || waddr !== 32'h40)
                ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fixed_stall_hold: wready=%b wr=%b wdata=%h, required 0 1 %h",
                     s_axi_wready, wr, wdata, exp_d[0]);
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        do_w(exp_d[1], 4'hF, 1'b0);
        do_w(exp_d[2], 4'hF, 1'b1);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 3) begin
            errors++;
            $display("FAIL fixed_count: writes=%0d, required 3", log_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ga, gd;
            ga = (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
            gd = (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx;
            checks++;
            if (ga !== 32'h40 || gd !== exp_d[i]) begin
                errors++;
                $display("FAIL fixed_beat%0d: waddr=%h wdata=%h, required 40 %h",
                         i, ga, gd, exp_d[i]);
            end
        end
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL fixed_bresp: bresp=%b, required 00", resp);
        end
    endtask

    task automatic test_span_cross();
        logic [7:0] id;
        logic [1:0] resp;
        clear_log();
        do_aw(8'h44, 32'hFF8, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            do_w(32'hC000_0000 + 32'(i), 4'hF, i == 3);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 2) begin
            errors++;
            $display("FAIL span_count: writes=%0d, required 2", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 32'hFF8 || log_addr[1] !== 32'hFFC) begin
                errors++;
                $display("FAIL span_addr: %h %h, required ff8 ffc",
                         log_addr[0], log_addr[1]);
            end
        end
        checks++;
        if (resp !== 2'b10) begin
            errors++;
            $display("FAIL span_bresp: bresp=%b, required 10", resp);
        end
    endtask

    task automatic test_early_last();
        logic [7:0] id;
        logic [1:0] resp;
        clear_log();
        do_aw(8'h07, 32'h80, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++)
            do_w(32'hD000_0000 + 32'(i), 4'hF, i == 2);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 3) begin
            errors++;
            $display("FAIL early_count: writes=%0d, required 3", log_addr.size());
        end
        checks++;
        if (resp !== 2'b10) begin
            errors++;
            $display("FAIL early_bresp: bresp=%b, required 10", resp);
        end
    endtask

    task automatic test_reserved();
        logic [7:0] id;
        logic [1:0] resp;
        clear_log();
        do_aw(8'h09, 32'h100, 8'd1, 3'd2, 2'b11);
        do_w(32'hE000_0000, 4'hF, 1'b0);
        do_w(32'hE000_0001, 4'hF, 1'b1);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL rsvd_count: writes=%0d, required 0", log_addr.size());
        end
        checks++;
        if (resp !== 2'b10 || id !== 8'h09) begin
            errors++;
            $display("FAIL rsvd_bresp: bresp=%b bid=%h, required 10 09", resp, id);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] id;
        logic [1:0] resp;
        wr_ready = 1'b0;
        do_aw(8'h66, 32'h200, 8'd3, 3'd2, 2'b01);
        do_w(32'hF000_0000, 4'hF, 1'b0);
        s_axi_wdata  = 32'hF000_0001;
        s_axi_wvalid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, wr} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: aw/w/b/wr=%b, required 0000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, wr});
        end
        checks++;
        if ({waddr, wdata, wstrb, s_axi_bid, s_axi_bresp, s_axi_buser} !== '0) begin
            errors++;
            $display("FAIL midrst_data: waddr=%h wdata=%h bid=%h bresp=%b, required 0",
                     waddr, wdata, s_axi_bid, s_axi_bresp);
        end
        s_axi_wvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        clear_log();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_awready: got %b, required 1", s_axi_awready);
        end
        @(posedge clk);
        #1;
        do_aw(8'h77, 32'h20, 8'd1, 3'd2, 2'b01);
        do_w(32'h0BAD_0000, 4'hF, 1'b0);
        do_w(32'h0BAD_0001, 4'hF, 1'b1);
        do_b(id, resp);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 32'h20 || log_addr[1] !== 32'h24) begin
            errors++;
            $display("FAIL midrst_fresh: writes=%0d, required 2 at 20 24",
                     log_addr.size());
        end
        checks++;
        if (resp !== 2'b00 || id !== 8'h77) begin
            errors++;
            $display("FAIL midrst_bresp: bresp=%b bid=%h, required 00 77", resp, id);
        end
    endtask

    initial begin
        test_reset();
        test_idle_w_blocked();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_span_cross();
        test_early_last();
        test_reserved();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
